// File: rtl/mux_logica_pkg.sv
// ============================================================================
//  Module   : mux_logica_pkg
//  Brief    : Shared operation codes and mode encodings for mux_logica_rr.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_logica_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_NOT  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    localparam logic MODO_FIJO = 1'b0;
    localparam logic MODO_RR   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mux_logica_rr_if.sv
// ============================================================================
//  Module   : mux_logica_rr_if
//  Brief    : Channel/operand/result bundle between producers and mux_logica_rr.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mux_logica_rr_if #(
    parameter int ANCHO   = 8,
    parameter int CANALES = 4,
    parameter int SELW    = $clog2(CANALES)
);
    logic [CANALES*ANCHO-1:0] datos_in;
    logic [CANALES-1:0]       valid_in;
    logic [ANCHO-1:0]         B;
    logic [1:0]               operacion;
    logic                     modo;
    logic [SELW-1:0]          selector;
    logic [ANCHO-1:0]         salida;
    logic                     valid_out;
    logic [SELW-1:0]          canal_out;
    logic                     sel_invalido;

    modport master (
        output datos_in, valid_in, B, operacion, modo, selector,
        input  salida, valid_out, canal_out, sel_invalido
    );

    modport slave (
        input  datos_in, valid_in, B, operacion, modo, selector,
        output salida, valid_out, canal_out, sel_invalido
    );
endinterface

`default_nettype wire

// File: rtl/mux_logica_rr_arbitro.sv
// ============================================================================
//  Module   : arbitro_rr
//  Brief    : Rotating-priority arbiter: first valid channel at or after ptr.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module arbitro_rr #(
    parameter int CANALES = 4,
    parameter int SELW    = $clog2(CANALES)
) (
    input  logic [CANALES-1:0] valid_i,
    input  logic [SELW-1:0]    ptr_i,
    output logic [SELW-1:0]    grant_o,
    output logic               grant_valid_o
);
    int k;

    // Walk from the farthest offset back to ptr so the nearest valid wins.
    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        k             = 0;
        for (int d = CANALES - 1; d >= 0; d--) begin
            k = int'(ptr_i) + d;
            if (k >= CANALES) begin
                k = k - CANALES;
            end
            if (valid_i[k]) begin
                grant_o       = SELW'(k);
                grant_valid_o = 1'b1;
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/mux_logica_rr.sv
// ============================================================================
//  Module   : mux_logica_rr
//  Brief    : Two-stage channel mux (fixed or round-robin) with bitwise op on B.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_logica_rr
    import mux_logica_pkg::*;
#(
    parameter int ANCHO   = 8,
    parameter int CANALES = 4,
    parameter int SELW    = $clog2(CANALES)
) (
    input  logic             clk,
    input  logic             reset,
    mux_logica_rr_if.slave   bus
);
    localparam int NPAD = 2 ** SELW;

    logic [ANCHO-1:0] w_canal [NPAD];
    logic [NPAD-1:0]  w_valid_pad;
    logic [SELW-1:0]  w_rr_idx;
    logic             w_rr_ok;
    logic             w_sel_ok;
    logic             w_grant;
    logic [SELW-1:0]  w_idx;
    logic [ANCHO-1:0] w_res;
    logic [SELW-1:0]  ptr_d;

    logic [SELW-1:0]  ptr_q;
    logic             v1_q;
    logic [ANCHO-1:0] a_q;
    logic [ANCHO-1:0] b_q;
    op_e              op_q;
    logic [SELW-1:0]  idx_q;
    logic [ANCHO-1:0] salida_q;
    logic             valid_out_q;
    logic [SELW-1:0]  canal_q;
    logic             sel_inv_q;

    // Pad to a power of two so an out-of-range selector reads an idle channel.
    generate
        for (genvar g = 0; g < NPAD; g++) begin : g_canal
            if (g < CANALES) begin : g_real
                assign w_canal[g]     = bus.datos_in[g*ANCHO +: ANCHO];
                assign w_valid_pad[g] = bus.valid_in[g];
            end else begin : g_pad
                assign w_canal[g]     = '0;
                assign w_valid_pad[g] = 1'b0;
            end
        end
    endgenerate

    arbitro_rr #(
        .CANALES (CANALES),
        .SELW    (SELW)
    ) u_arbitro (
        .valid_i       (bus.valid_in),
        .ptr_i         (ptr_q),
        .grant_o       (w_rr_idx),
        .grant_valid_o (w_rr_ok)
    );

    always_comb begin
        w_sel_ok = (int'(bus.selector) < CANALES);
        w_grant  = 1'b0;
        w_idx    = bus.selector;
        ptr_d    = ptr_q;
        if (bus.modo == MODO_RR) begin
            w_grant = w_rr_ok;
            w_idx   = w_rr_idx;
            if (w_rr_ok) begin
                ptr_d = (w_rr_idx == SELW'(CANALES - 1)) ? '0 : w_rr_idx + SELW'(1);
            end
        end else begin
            w_grant = w_sel_ok && w_valid_pad[bus.selector];
        end
    end

    always_comb begin
        w_res = a_q;
        case (op_q)
            OP_AND:  w_res = a_q & b_q;
            OP_OR:   w_res = a_q | b_q;
            OP_NOT:  w_res = ~a_q;
            OP_PASS: w_res = a_q;
            default: w_res = a_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            v1_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_AND;
            idx_q       <= '0;
            salida_q    <= '0;
            valid_out_q <= 1'b0;
            canal_q     <= '0;
            sel_inv_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            v1_q        <= w_grant;
            sel_inv_q   <= (bus.modo == MODO_FIJO) && !w_sel_ok;
            valid_out_q <= v1_q;
            if (w_grant) begin
                a_q   <= w_canal[w_idx];
                b_q   <= bus.B;
                op_q  <= op_e'(bus.operacion);
                idx_q <= w_idx;
            end
            if (v1_q) begin
                salida_q <= w_res;
                canal_q  <= idx_q;
            end
        end
    end

    assign bus.salida       = salida_q;
    assign bus.valid_out    = valid_out_q;
    assign bus.canal_out    = canal_q;
    assign bus.sel_invalido = sel_inv_q;
endmodule

`default_nettype wire

// File: tb/tb_mux_logica_rr.sv
// ============================================================================
//  Module   : tb_mux_logica_rr
//  Brief    : Self-checking bench for mux_logica_rr (4- and 3-channel builds).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_logica_rr;
    import mux_logica_pkg::*;

    localparam int C  = 4;
    localparam int C3 = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mux_logica_rr_if #(.ANCHO(8), .CANALES(C))  if4();
    mux_logica_rr_if #(.ANCHO(8), .CANALES(C3)) if3();

    mux_logica_rr #(.ANCHO(8), .CANALES(C))  dut4 (.clk(clk), .reset(reset), .bus(if4.slave));
    mux_logica_rr #(.ANCHO(8), .CANALES(C3)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave));

    int checks   = 0;
    int failures = 0;

    // Behavioural reference for the 4-channel build.
    int         m_ptr;
    logic       m_s1v;
    logic [7:0] m_s1d;
    int         m_s1c;
    logic [7:0] m_sal;
    int         m_can;
    logic       m_vout;
    logic       m_selinv;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [4];
    int   rr_exp [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 3, 1, 3};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] f_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~a;
            default: return a;
        endcase
    endfunction

    task automatic model_clear();
        m_ptr = 0; m_s1v = 0; m_s1d = 0; m_s1c = 0;
        m_sal = 0; m_can = 0; m_vout = 0; m_selinv = 0;
    endtask

    // One clock: model sees the inputs presented before the edge, then compares.
    task automatic tick();
        logic       gv, r, sinv;
        int         g, bd, d;
        logic [7:0] res;
        gv = 0; g = 0; bd = C;
        r  = reset;
        if (if4.modo) begin
            for (int k = 0; k < C; k++) begin
                d = (k - m_ptr + C) % C;
                if (if4.valid_in[k] && d < bd) begin
                    bd = d; g = k; gv = 1;
                end
            end
        end else if (int'(if4.selector) < C && if4.valid_in[if4.selector]) begin
            gv = 1; g = int'(if4.selector);
        end
        res  = f_op(if4.datos_in[g*8 +: 8], if4.B, if4.operacion);
        sinv = !if4.modo && (int'(if4.selector) >= C);
        @(posedge clk);
        #1;
        if (r) begin
            model_clear();
        end else begin
            m_vout = m_s1v;
            if (m_s1v) begin
                m_sal = m_s1d;
                m_can = m_s1c;
            end
            m_s1v = gv;
            if (gv) begin
                m_s1d = res;
                m_s1c = g;
            end
            if (if4.modo && gv) m_ptr = (g + 1) % C;
            m_selinv = sinv;
        end
        chk("m_valid_out", 32'(if4.valid_out), 32'(m_vout));
        chk("m_salida", 32'(if4.salida), 32'(m_sal));
        chk("m_canal_out", 32'(if4.canal_out), 32'(m_can));
        chk("m_sel_invalido", 32'(if4.sel_invalido), 32'(m_selinv));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        tbl[0] = '{8'hA5, 8'h0F, 2'b00, 8'h05};
        tbl[1] = '{8'hA5, 8'h0F, 2'b01, 8'hAF};
        tbl[2] = '{8'hA5, 8'h0F, 2'b10, 8'h5A};
        tbl[3] = '{8'hA5, 8'h0F, 2'b11, 8'hA5};

        model_clear();
        reset = 1'b1;
        if4.datos_in = 32'h44332211; if4.valid_in = 4'b1111; if4.B = 8'h0F;
        if4.operacion = 2'b11; if4.modo = 1'b1; if4.selector = 2'd0;
        if3.datos_in = 24'h0; if3.valid_in = 3'b000; if3.B = 8'h00;
        if3.operacion = 2'b11; if3.modo = 1'b0; if3.selector = 2'd0;

        // Reset held with all channels valid
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_valid_out", 32'(if4.valid_out), 32'd0);
            chk("rst_salida", 32'(if4.salida), 32'd0);
            chk("rst_canal_out", 32'(if4.canal_out), 32'd0);
        end
        reset = 1'b0;
        tick();
        chk("post_rst_vout_c1", 32'(if4.valid_out), 32'd0);
        tick();
        chk("post_rst_vout_c2", 32'(if4.valid_out), 32'd1);
        chk("post_rst_canal", 32'(if4.canal_out), 32'd0);
        chk("post_rst_salida", 32'(if4.salida), 32'h11);

        // Fixed selector, table of operations on channel 2
        do_reset();
        if4.modo = MODO_FIJO; if4.selector = 2'd2;
        for (int j = 0; j <= 4; j++) begin
            if (j < 4) begin
                if4.datos_in  = {8'h00, tbl[j].a, 16'h0000};
                if4.B         = tbl[j].b;
                if4.operacion = tbl[j].op;
                if4.valid_in  = 4'b0100;
            end else begin
                if4.valid_in  = 4'b0000;
            end
            tick();
            if (j >= 1) begin
                chk("fix_salida", 32'(if4.salida), 32'(tbl[j-1].exp));
                chk("fix_canal", 32'(if4.canal_out), 32'd2);
                chk("fix_vout", 32'(if4.valid_out), 32'd1);
            end
        end
        tick();
        chk("fix_idle_vout", 32'(if4.valid_out), 32'd0);
        chk("fix_hold_salida", 32'(if4.salida), 32'hA5);

        // Round-robin rotation, then a sparse pattern
        do_reset();
        if4.modo = MODO_RR; if4.datos_in = 32'hD4C3B2A1; if4.operacion = 2'b11;
        for (int j = 0; j <= 12; j++) begin
            if4.valid_in = (j < 8) ? 4'b1111 : (j < 12) ? 4'b1010 : 4'b0000;
            tick();
            if (j >= 1) begin
                chk("rr_canal", 32'(if4.canal_out), 32'(rr_exp[j-1]));
                chk("rr_vout", 32'(if4.valid_out), 32'd1);
            end
        end

        // Wrap from ptr=3 to channel 0, then idle keeps ptr at 1
        if4.valid_in = 4'b0100; tick();
        if4.valid_in = 4'b0001; tick();
        chk("wrap_prev_canal", 32'(if4.canal_out), 32'd2);
        if4.valid_in = 4'b0000; tick();
        chk("wrap_canal", 32'(if4.canal_out), 32'd0);
        chk("wrap_salida", 32'(if4.salida), 32'hA1);
        tick();
        chk("idle_vout1", 32'(if4.valid_out), 32'd0);
        tick();
        chk("idle_vout2", 32'(if4.valid_out), 32'd0);
        if4.valid_in = 4'b1111; tick();
        if4.valid_in = 4'b0000; tick();
        chk("ptr_kept_canal", 32'(if4.canal_out), 32'd1);
        chk("ptr_kept_vout", 32'(if4.valid_out), 32'd1);

        // Three-channel build: out-of-range selector
        if3.modo = MODO_FIJO; if3.selector = 2'd3; if3.valid_in = 3'b111;
        if3.datos_in = 24'h773C11;
        tick();
        chk("inv_flag1", 32'(if3.sel_invalido), 32'd1);
        chk("inv_vout1", 32'(if3.valid_out), 32'd0);
        if3.selector = 2'd1;
        tick();
        chk("inv_vout2", 32'(if3.valid_out), 32'd0);
        chk("inv_flag2", 32'(if3.sel_invalido), 32'd0);
        if3.valid_in = 3'b000;
        tick();
        chk("c3_vout", 32'(if3.valid_out), 32'd1);
        chk("c3_canal", 32'(if3.canal_out), 32'd1);
        chk("c3_salida", 32'(if3.salida), 32'h3C);

        // Reset one cycle after a grant drops the in-flight result
        if4.valid_in = 4'b1111; tick();
        reset = 1'b1; tick();
        chk("mid_vout", 32'(if4.valid_out), 32'd0);
        chk("mid_salida", 32'(if4.salida), 32'd0);
        chk("mid_canal", 32'(if4.canal_out), 32'd0);
        reset = 1'b0; if4.valid_in = 4'b0000; tick();
        chk("mid_vout_after", 32'(if4.valid_out), 32'd0);
        tick();
        chk("mid_vout_after2", 32'(if4.valid_out), 32'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 39) == 0);
            if4.modo      = 1'($urandom_range(0, 1));
            if4.selector  = 2'($urandom_range(0, 3));
            if4.valid_in  = 4'($urandom_range(0, 15));
            if4.datos_in  = $urandom;
            if4.B         = 8'($urandom_range(0, 255));
            if4.operacion = 2'($urandom_range(0, 3));
            tick();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/mux_logica_rr.md
Name: mux_logica_rr

Overview:
- Parametrised successor of the 1-bit AND/OR/NOT/mux cell group: an ANCHO-bit, CANALES-input registered logic multiplexer.
- Selects one input channel either by explicit selector or by round-robin arbitration among valid channels.
- Applies a selectable bitwise operation against operand B.
- Two-stage pipeline; each result is tagged with its source channel. Sits between the channel producers and the downstream checker/probador.

Parameters:
- ANCHO, 8, data width of each channel, B and salida (>=1)
- CANALES, 4, number of input channels (>=2); SELW = $clog2(CANALES)

Ports:
- clk  input  1  single rising-edge clock
- reset  input  1  synchronous, active-high reset
- datos_in  input  CANALES*ANCHO  channel k occupies bits [k*ANCHO +: ANCHO]
- valid_in  input  CANALES  per-channel data-valid
- B  input  ANCHO  second operand
- operacion  input  2  00 AND, 01 OR, 10 NOT(A), 11 pass A
- modo  input  1  0 = fixed selector, 1 = round-robin
- selector  input  SELW  channel index used when modo=0
- salida  output  ANCHO  registered result
- valid_out  output  1  salida/canal_out are meaningful
- canal_out  output  SELW  channel that produced salida
- sel_invalido  output  1  registered flag: selector >= CANALES while modo=0

Behaviour:
- Reset is synchronous, active-high, and dominates every other input on the same edge.
- On reset: salida=0, valid_out=0, canal_out=0, sel_invalido=0, round-robin pointer=0, stage-1 registers cleared (valid=0).
- Reset asserted mid-operation drops any in-flight data; the first valid_out after deassertion is 2 cycles after the first accepted input.

Stage 1, every edge:
- modo=0, selector<CANALES and valid_in[selector]=1: grant = selector.
- modo=0, selector<CANALES and valid_in[selector]=0: no grant.
- modo=0, selector>=CANALES (non-power-of-2 CANALES only): no grant; sel_invalido=1 next cycle, otherwise 0.
- modo=1: grant = first k with valid_in[k]=1, searching ptr, ptr+1, ... wrapping modulo CANALES. On a grant, ptr <= (grant+1) mod CANALES. No valid channel: no grant, ptr unchanged.
- ptr updates only in modo=1. Switching modo does not reset ptr.
- Captured together on a grant: A = channel data, B, operacion, grant index. Stage-1 valid = grant.

Stage 2, every edge:
- salida <= op(A,B) using the captured operacion.
- canal_out <= captured index; valid_out <= stage-1 valid.
- With no valid entry, salida and canal_out hold their previous values and valid_out=0.
- Ops are bitwise over ANCHO bits; NOT ignores B; no carries, no width growth.

Timing and flow:
- Latency is exactly 2 clocks from a grant edge to valid_out. Throughput is 1 result per clock; there is no backpressure.
- Ungranted valid channels are not stored. Producers must hold valid_in until they see their index on canal_out, or accept the loss.
- With all channels continuously valid in modo=1, grants rotate 0,1,...,CANALES-1,0. No channel waits more than CANALES-1 grants.

Decomposition:
- Shared package mux_logica_pkg holds: op codes OP_AND=2'b00, OP_OR=2'b01, OP_NOT=2'b10, OP_PASS=2'b11; MODO_FIJO=0, MODO_RR=1.
- One sub-module: arbitro_rr (CANALES-wide rotating-priority arbiter: valid vector + ptr -> grant index, grant flag). Unit-tested separately.
- Stage registers and the op decode stay in mux_logica_rr.

Test Plan:
- Reset: hold reset 3 cycles with all channels valid -> salida=0, valid_out=0, canal_out=0 throughout; first valid_out exactly 2 cycles after reset drops.
- Fixed mode: ANCHO=8, modo=0, selector=2, ch2=8'hA5, B=8'h0F, operacion cycles 00,01,10,11 -> salida 8'h05, 8'hAF, 8'h5A, 8'hA5 on consecutive cycles, each 2 clocks after its input; canal_out=2.
- Round-robin: modo=1, valid_in=4'b1111 for 8 cycles -> canal_out 0,1,2,3,0,1,2,3. Then valid_in=4'b1010 -> 1,3,1,3.
- Wrap/skip: ptr=3, valid_in=4'b0001 -> grant 0, next ptr=1. Then valid_in=0 for 2 cycles -> valid_out=0, ptr stays 1.
- Invalid selector: CANALES=3, modo=0, selector=3 with valid_in=3'b111 -> no valid_out, sel_invalido=1 one cycle later.
- Reset mid-flight: grant on cycle N, reset at N+1 -> no valid_out at N+2; all outputs zero.
